// File: rtl/fwd_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// fwd_hazard_ctrl_if
//   Bundles the decode-stage request, pipeline-stage status, completion bus
//   and controller responses of fwd_hazard_ctrl.
//   master : drives decode/stage/completion inputs, receives selects/stall
//   slave  : the controller itself
//   Signals:
//     i_opcode, i_rs1, i_rs2, i_rd, i_rd_write, i_issue_lat  decode instruction
//     i_stg_reg_write, i_stg_rd, i_stg_data_vld             per-stage status
//     i_cmpl_valid, i_cmpl_rd                               long-latency writeback
//     i_stall_cnt_clr                                       stall counter clear
//     o_forward_a/b, o_stall, o_sb_full, o_sb_err, o_stall_cnt  responses
// ----------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 2)
);
    logic [6:0]              i_opcode;
    logic [4:0]              i_rs1;
    logic [4:0]              i_rs2;
    logic [4:0]              i_rd;
    logic                    i_rd_write;
    logic                    i_issue_lat;
    logic [FWD_STAGES-1:0]   i_stg_reg_write;
    logic [5*FWD_STAGES-1:0] i_stg_rd;
    logic [FWD_STAGES-1:0]   i_stg_data_vld;
    logic                    i_cmpl_valid;
    logic [4:0]              i_cmpl_rd;
    logic                    i_stall_cnt_clr;
    logic [SEL_W-1:0]        o_forward_a;
    logic [SEL_W-1:0]        o_forward_b;
    logic                    o_stall;
    logic                    o_sb_full;
    logic                    o_sb_err;
    logic [31:0]             o_stall_cnt;

    modport master (
        output i_opcode, i_rs1, i_rs2, i_rd, i_rd_write, i_issue_lat,
               i_stg_reg_write, i_stg_rd, i_stg_data_vld,
               i_cmpl_valid, i_cmpl_rd, i_stall_cnt_clr,
        input  o_forward_a, o_forward_b, o_stall, o_sb_full, o_sb_err, o_stall_cnt
    );

    modport slave (
        input  i_opcode, i_rs1, i_rs2, i_rd, i_rd_write, i_issue_lat,
               i_stg_reg_write, i_stg_rd, i_stg_data_vld,
               i_cmpl_valid, i_cmpl_rd, i_stall_cnt_clr,
        output o_forward_a, o_forward_b, o_stall, o_sb_full, o_sb_err, o_stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Decode-stage forwarding and hazard controller. Chooses the rs1/rs2 operand
//   source (register file, one of FWD_STAGES pipeline stages, or the
//   long-latency completion bus), raises stall on load-use, scoreboard and
//   in-flight-limit hazards, tracks pending long-latency destinations and
//   counts stalled cycles.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  synchronous reset, active low
//     bus      fwd_hazard_ctrl_if.slave (all request/response signals)
//   Select encoding: 0 = register file, k+1 = stage k, FWD_STAGES+1 = completion.
// ----------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int FWD_STAGES = 2,
    parameter int MAX_OUTST  = 4,
    parameter int SEL_W      = $clog2(FWD_STAGES + 2)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fwd_hazard_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [SEL_W-1:0] CMPL_SEL = SEL_W'(FWD_STAGES + 1);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_PIM    = 7'b0001011;

    logic [31:0]      sb_pend_p1;
    logic [CNT_W-1:0] sb_cnt_p1;
    logic             sb_err_p1;
    logic [31:0]      stall_cnt_p1;

    logic [31:0]      cmpl_mask;
    logic [31:0]      eff_pend;
    logic [31:0]      pend_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             use_a, use_b;
    logic             hit_a, hit_b, lu_a, lu_b;
    logic [SEL_W-1:0] stg_sel_a, stg_sel_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             stall_a, stall_b, stall_waw, stall_full, stall;
    logic             issue_ok, cmpl_ok, cmpl_err;

    // Youngest matching stage wins: scan oldest to youngest so the last hit sticks.
    function automatic void fwd_pick(
        input  logic [4:0]              rs,
        input  logic [FWD_STAGES-1:0]   wr,
        input  logic [5*FWD_STAGES-1:0] rd,
        input  logic [FWD_STAGES-1:0]   vld,
        output logic                    hit,
        output logic                    load_use,
        output logic [SEL_W-1:0]        sel
    );
        hit      = 1'b0;
        load_use = 1'b0;
        sel      = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (wr[k] && (rd[5*k +: 5] == rs)) begin
                hit      = 1'b1;
                load_use = !vld[k];
                sel      = SEL_W'(k + 1);
            end
        end
    endfunction

    // ---- decode stage (p0): combinational source select and hazard detect ----
    always_comb begin
        use_a = !((bus.i_opcode == OP_JAL) || (bus.i_opcode == OP_LUI) ||
                  (bus.i_opcode == OP_AUIPC));
        use_b = (bus.i_opcode == OP_R) || (bus.i_opcode == OP_STORE) ||
                (bus.i_opcode == OP_BRANCH) || (bus.i_opcode == OP_PIM);

        // A completing register is no longer a hazard in the cycle it completes.
        cmpl_mask = bus.i_cmpl_valid ? (32'd1 << bus.i_cmpl_rd) : 32'd0;
        eff_pend  = sb_pend_p1 & ~cmpl_mask;

        fwd_pick(bus.i_rs1, bus.i_stg_reg_write, bus.i_stg_rd, bus.i_stg_data_vld,
                 hit_a, lu_a, stg_sel_a);
        fwd_pick(bus.i_rs2, bus.i_stg_reg_write, bus.i_stg_rd, bus.i_stg_data_vld,
                 hit_b, lu_b, stg_sel_b);

        sel_a   = '0;
        stall_a = 1'b0;
        if (use_a && (bus.i_rs1 != 5'd0)) begin
            if (hit_a) begin
                sel_a   = stg_sel_a;
                stall_a = lu_a;
            end else begin
                if (bus.i_cmpl_valid && (bus.i_cmpl_rd == bus.i_rs1)) sel_a = CMPL_SEL;
                stall_a = eff_pend[bus.i_rs1];
            end
        end

        sel_b   = '0;
        stall_b = 1'b0;
        if (use_b && (bus.i_rs2 != 5'd0)) begin
            if (hit_b) begin
                sel_b   = stg_sel_b;
                stall_b = lu_b;
            end else begin
                if (bus.i_cmpl_valid && (bus.i_cmpl_rd == bus.i_rs2)) sel_b = CMPL_SEL;
                stall_b = eff_pend[bus.i_rs2];
            end
        end

        stall_waw  = bus.i_rd_write && eff_pend[bus.i_rd];
        stall_full = bus.i_issue_lat && (sb_cnt_p1 == CNT_W'(MAX_OUTST)) && !bus.i_cmpl_valid;
        stall      = i_rst_n && (stall_a || stall_b || stall_waw || stall_full);

        issue_ok = bus.i_issue_lat && bus.i_rd_write && (bus.i_rd != 5'd0) && !stall;
        cmpl_ok  = bus.i_cmpl_valid && sb_pend_p1[bus.i_cmpl_rd];
        cmpl_err = bus.i_cmpl_valid && !sb_pend_p1[bus.i_cmpl_rd];

        // Clear before set so a same-cycle issue to the completing rd stays pending.
        pend_nxt = sb_pend_p1;
        if (cmpl_ok)  pend_nxt[bus.i_cmpl_rd] = 1'b0;
        if (issue_ok) pend_nxt[bus.i_rd]      = 1'b1;

        case ({issue_ok, cmpl_ok})
            2'b10:   cnt_nxt = sb_cnt_p1 + CNT_W'(1);
            2'b01:   cnt_nxt = sb_cnt_p1 - CNT_W'(1);
            default: cnt_nxt = sb_cnt_p1;
        endcase
    end

    // ---- scoreboard / counter state (p1) ----
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sb_pend_p1   <= '0;
            sb_cnt_p1    <= '0;
            sb_err_p1    <= 1'b0;
            stall_cnt_p1 <= '0;
        end else begin
            sb_pend_p1 <= pend_nxt;
            sb_cnt_p1  <= cnt_nxt;
            sb_err_p1  <= cmpl_err;
            if (bus.i_stall_cnt_clr)
                stall_cnt_p1 <= '0;
            else if (stall && (stall_cnt_p1 != 32'hFFFF_FFFF))
                stall_cnt_p1 <= stall_cnt_p1 + 32'd1;
        end
    end

    assign bus.o_forward_a = i_rst_n ? sel_a : '0;
    assign bus.o_forward_b = i_rst_n ? sel_b : '0;
    assign bus.o_stall     = stall;
    assign bus.o_sb_full   = (sb_cnt_p1 == CNT_W'(MAX_OUTST));
    assign bus.o_sb_err    = sb_err_p1;
    assign bus.o_stall_cnt = stall_cnt_p1;

endmodule
